microwave_controller: RTL and testbench
=======================================

Name: microwave_controller

Overview:
Microwave-oven controller for a board-level demo. It takes one-hot keypad switches and active-low start/stop/clear buttons plus a door sensor. It holds an M:S:S cook time (minutes, tens-of-seconds, seconds), counts it down at 1 Hz while the magnetron runs, and drives three active-low 7-segment displays. It is the top level of the oven datapath and owns the 1 Hz prescaler.

Parameters:
CLK_DIV, 50_000_000, clk cycles per 1 Hz tick (benches override to 10)

Ports:
clk  in  1  system clock, all flops rising-edge
clearn  in  1  asynchronous active-low reset / clear button
switches  in  [0:9]  keypad; switches[i]=1 means digit i pressed
startn  in  1  start button, active-low, level
stopn  in  1  stop button, active-low, level
door_closed  in  1  1 = door closed
magn_on  out  1  magnetron enable
timerdone  out  1  cook time expired
pgt_1Hz  out  1  one-clk pulse every CLK_DIV cycles
outMin  out  7  minutes digit, segments {g,f,e,d,c,b,a}, active-low
outTenSec  out  7  tens-of-seconds digit, same encoding
outSec  out  7  seconds digit, same encoding

Behaviour:
- Reset (clearn=0, asynchronous):
  - state=IDLE, all digits=0, prescaler=0, switch-edge register=0.
  - magn_on=0, timerdone=0, pgt_1Hz=0.
  - All three displays show "0" (1000000).
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - pgt_1Hz=1 for exactly the one cycle where count==CLK_DIV-1.
  - Free-running in every state.
- Keypad entry:
  - switches are registered each clk; a digit event is a 0->1 edge on any bit.
  - If several bits rise in the same cycle, the lowest index wins.
  - Accepted only in IDLE or DONE; ignored in COOK.
  - On an event: min<=tens, tens<=sec, sec<=digit. In DONE the event also moves state to IDLE and clears timerdone.
  - Digits are stored as 4-bit BCD 0..9; tens may hold 6..9 as entered.
- States IDLE / COOK / DONE, registered:
  - IDLE->COOK: when startn=0, stopn=1, door_closed=1 and time!=000.
  - COOK->IDLE (pause, time retained): when stopn=0 or door_closed=0.
  - COOK->DONE: on a pgt_1Hz cycle where time==001 (decrements to 000).
  - DONE->IDLE: on stopn=0 or a digit event.
  - startn is ignored in COOK and DONE. stopn has priority over startn.
- Countdown: decrement only in COOK when pgt_1Hz=1.
  - sec>0: sec-1.
  - Else if tens>0: tens-1, sec=9.
  - Else: min-1, tens=5, sec=9.
  - Underflow below 000 cannot occur.
- Outputs:
  - magn_on = (state==COOK). It asserts the cycle after the start conditions are sampled and drops the cycle after a stop, door-open or done condition.
  - timerdone = (state==DONE).
- Door opening during COOK stops the magnetron at the next edge; closing the door does not auto-resume, start must be pressed again.
- Segment codes (gfedcba, active-low):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  Other codes are unreachable; drive 1111111 (blank).

Test Plan:
- Reset release: all inputs 0, clearn 0->1, door_closed 0->1, no keys -> magn_on=0, timerdone=0, all displays 1000000; startn=0 with time 000 stays IDLE.
- Entry: CLK_DIV=10; press 1,2,5 (one rising edge each) -> outMin=1111001, outTenSec=0100100, outSec=0010010; a held key produces only one shift.
- Cook and countdown: time 0:05, door closed, pulse startn low -> magn_on=1 next cycle; after 5 pgt_1Hz pulses time=000, magn_on=0, timerdone=1; 1:00 decrements to 0:59.
- Pause: in COOK, open door -> magn_on=0 next cycle with time frozen; close door, pulse startn -> resumes from frozen value. Repeat with stopn=0 -> same pause; startn and stopn low together -> stays IDLE.
- Done exit: in DONE, press key 3 -> IDLE, timerdone=0, time 0:03; keys pressed during COOK do not alter the time.
- Async clear: assert clearn mid-COOK between clock edges -> magn_on, timerdone and digits go to 0 immediately; pgt_1Hz period restarts from 0 after release.

Source files
------------

// File: rtl/microwave_controller.sv
// Microwave oven controller: keypad entry of an M:S:S cook time, 1 Hz countdown while cooking, 7-seg display drive.
// Latency: keypad digit, start/stop and door changes take effect on the next rising clk edge.
// No flow control: stop/door-open override start, keys are ignored while cooking.
module microwave_controller #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [0:9] switches,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       magn_on,
  output logic       timerdone,
  output logic       pgt_1Hz,
  output logic [6:0] outMin,
  output logic [6:0] outTenSec,
  output logic [6:0] outSec
);

  typedef enum logic [1:0] {IDLE, COOK, DONE} state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:9]    sw_q, sw_d;
  logic [0:9]    sw_rise;
  logic [3:0]    min_q, min_d, ten_q, ten_d, sec_q, sec_d;
  logic          tick;
  logic          key_vld;
  logic [3:0]    key_dat;
  logic          time_zero, time_one, start_ok, pause_req;

  // Active-low 7-segment decode, gfedcba; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Free-running prescaler; the tick is the last count of each period.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Keypad rising-edge detect; walking down from 9 lets the lowest index win.
  always_comb begin
    sw_d    = switches;
    sw_rise = switches & ~sw_q;
    key_vld = 1'b0;
    key_dat = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (sw_rise[i]) begin
        key_vld = 1'b1;
        key_dat = 4'(i);
      end
    end
  end

  // Next-state and cook-time update.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    ten_d     = ten_q;
    sec_d     = sec_q;
    time_zero = (min_q == 4'd0) && (ten_q == 4'd0) && (sec_q == 4'd0);
    time_one  = (min_q == 4'd0) && (ten_q == 4'd0) && (sec_q == 4'd1);
    start_ok  = !startn && stopn && door_closed && !time_zero;
    pause_req = !stopn || !door_closed;
    case (state_q)
      IDLE: begin
        if (key_vld) begin
          min_d = ten_q;
          ten_d = sec_q;
          sec_d = key_dat;
        end
        if (start_ok) state_d = COOK;
      end
      COOK: begin
        // A pause wins over a coincident tick so the shown time is the frozen one.
        if (pause_req) begin
          state_d = IDLE;
        end else if (tick) begin
          if (sec_q != 4'd0) begin
            sec_d = sec_q - 4'd1;
          end else if (ten_q != 4'd0) begin
            ten_d = ten_q - 4'd1;
            sec_d = 4'd9;
          end else begin
            min_d = min_q - 4'd1;
            ten_d = 4'd5;
            sec_d = 4'd9;
          end
          if (time_one) state_d = DONE;
        end
      end
      DONE: begin
        if (key_vld) begin
          min_d = ten_q;
          ten_d = sec_q;
          sec_d = key_dat;
        end
        if (!stopn || key_vld) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, prescaler, keypad history and time digits.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sw_q    <= '0;
      min_q   <= 4'd0;
      ten_q   <= 4'd0;
      sec_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      min_q   <= min_d;
      ten_q   <= ten_d;
      sec_q   <= sec_d;
    end
  end

  assign magn_on   = (state_q == COOK);
  assign timerdone = (state_q == DONE);
  assign pgt_1Hz   = tick;
  assign outMin    = seg7(min_q);
  assign outTenSec = seg7(ten_q);
  assign outSec    = seg7(sec_q);

endmodule

// File: tb/tb_microwave_controller.sv
// Bench for microwave_controller with a 10-cycle prescaler.
// Inputs change on falling edges; outputs are sampled on falling edges.
// Table of IDLE-state keypad vectors plus hand sequences for cooking, pause, done and clear.
module tb_microwave_controller;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       clearn;
  logic [0:9] switches;
  logic       startn, stopn, door_closed;
  logic       magn_on, timerdone, pgt_1Hz;
  logic [6:0] outMin, outTenSec, outSec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  microwave_controller #(.CLK_DIV(DIV)) dut (
    .clk(clk), .clearn(clearn), .switches(switches), .startn(startn),
    .stopn(stopn), .door_closed(door_closed), .magn_on(magn_on),
    .timerdone(timerdone), .pgt_1Hz(pgt_1Hz), .outMin(outMin),
    .outTenSec(outTenSec), .outSec(outSec)
  );

  typedef struct {
    logic [0:9] sw;
    logic       startn, stopn, door;
    logic       exp_magn, exp_done;
    int         m, t, s;
  } vec_t;

  vec_t vt[17];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [0:9] key(input int d);
    logic [0:9] k;
    k = '0;
    if (d >= 0 && d <= 9) k[d] = 1'b1;
    return k;
  endfunction

  function automatic vec_t mk(input logic [0:9] sw, input logic st, input logic sp,
                              input logic dr, input logic em, input logic ed,
                              input int m, input int t, input int s);
    vec_t v;
    v.sw = sw; v.startn = st; v.stopn = sp; v.door = dr;
    v.exp_magn = em; v.exp_done = ed; v.m = m; v.t = t; v.s = s;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int t, input int s);
    chk({tag, ".min"}, outMin, seg(m));
    chk({tag, ".ten"}, outTenSec, seg(t));
    chk({tag, ".sec"}, outSec, seg(s));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts falling edges until pgt_1Hz is seen high (checked before stepping).
  task automatic wait_pgt(input string tag, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i <= 40; i++) begin
      if (pgt_1Hz) begin
        found = 1'b1;
        n = i;
        break;
      end
      step();
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: pgt_1Hz timeout got none expected pulse within 40 cycles", tag);
    end
  endtask

  initial begin
    int n;
    vt[0]  = mk(key(1),          1, 1, 1, 0, 0, 0, 0, 1);
    vt[1]  = mk(key(-1),         1, 1, 1, 0, 0, 0, 0, 1);
    vt[2]  = mk(key(2),          1, 1, 1, 0, 0, 0, 1, 2);
    vt[3]  = mk(key(2),          1, 1, 1, 0, 0, 0, 1, 2);
    vt[4]  = mk(key(-1),         1, 1, 1, 0, 0, 0, 1, 2);
    vt[5]  = mk(key(5),          1, 1, 1, 0, 0, 1, 2, 5);
    vt[6]  = mk(key(-1),         1, 1, 1, 0, 0, 1, 2, 5);
    vt[7]  = mk(key(7) | key(4), 1, 1, 1, 0, 0, 2, 5, 4);
    vt[8]  = mk(key(-1),         1, 1, 1, 0, 0, 2, 5, 4);
    vt[9]  = mk(key(0),          1, 1, 1, 0, 0, 5, 4, 0);
    vt[10] = mk(key(-1),         1, 1, 1, 0, 0, 5, 4, 0);
    vt[11] = mk(key(0),          1, 1, 1, 0, 0, 4, 0, 0);
    vt[12] = mk(key(-1),         1, 1, 1, 0, 0, 4, 0, 0);
    vt[13] = mk(key(5),          1, 1, 1, 0, 0, 0, 0, 5);
    vt[14] = mk(key(-1),         0, 0, 1, 0, 0, 0, 0, 5);
    vt[15] = mk(key(-1),         1, 0, 1, 0, 0, 0, 0, 5);
    vt[16] = mk(key(-1),         1, 1, 1, 0, 0, 0, 0, 5);

    // Reset state, sampled between edges while clearn is low.
    clearn = 1'b0; switches = '0; startn = 1'b0; stopn = 1'b0; door_closed = 1'b0;
    #12;
    chk("rst.magn", magn_on, 0);
    chk("rst.done", timerdone, 0);
    chk("rst.pgt", pgt_1Hz, 0);
    chk_time("rst", 0, 0, 0);
    @(negedge clk);
    clearn = 1'b1;
    step(); step();
    chk("rel.magn", magn_on, 0);
    door_closed = 1'b1; stopn = 1'b1; startn = 1'b0;
    repeat (3) step();
    chk("start_zero.magn", magn_on, 0);
    chk("start_zero.done", timerdone, 0);
    startn = 1'b1;

    // Keypad entry vectors in IDLE.
    for (int i = 0; i < 17; i++) begin
      switches = vt[i].sw; startn = vt[i].startn; stopn = vt[i].stopn; door_closed = vt[i].door;
      step();
      chk($sformatf("vec%0d.magn", i), magn_on, vt[i].exp_magn);
      chk($sformatf("vec%0d.done", i), timerdone, vt[i].exp_done);
      chk_time($sformatf("vec%0d", i), vt[i].m, vt[i].t, vt[i].s);
    end

    // Cook 0:05 to completion, checking every decrement and the tick period.
    startn = 1'b0;
    step();
    chk("cook5.magn_on", magn_on, 1);
    startn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_pgt("cook5.wait", n);
      if (k > 1) chk("cook5.period", n + 1, DIV);
      step();
      chk_time($sformatf("cook5.t%0d", k), 0, 0, 5 - k);
      chk($sformatf("cook5.magn%0d", k), magn_on, (k < 5) ? 1 : 0);
      chk($sformatf("cook5.done%0d", k), timerdone, (k == 5) ? 1 : 0);
    end

    // Key in DONE returns to IDLE and shifts in the digit.
    switches = key(3);
    step();
    switches = '0;
    chk("done_exit.done", timerdone, 0);
    chk("done_exit.magn", magn_on, 0);
    chk_time("done_exit", 0, 0, 3);

    // Cook from 0:03; a key pressed mid-cook must not change the time.
    startn = 1'b0;
    step();
    startn = 1'b1;
    chk("cook3.magn", magn_on, 1);
    wait_pgt("cook3.wait", n);
    step();
    chk_time("cook3.t1", 0, 0, 2);
    switches = key(7);
    step();
    switches = '0;
    step();
    chk_time("cook3.key_ignored", 0, 0, 2);

    // Door open pauses with the time frozen; closing does not resume.
    door_closed = 1'b0;
    step();
    chk("door.magn", magn_on, 0);
    chk_time("door.frozen", 0, 0, 2);
    repeat (15) step();
    chk_time("door.still", 0, 0, 2);
    door_closed = 1'b1;
    repeat (3) step();
    chk("door.no_resume", magn_on, 0);
    startn = 1'b0;
    step();
    startn = 1'b1;
    chk("door.resume", magn_on, 1);
    wait_pgt("door.wait", n);
    step();
    chk_time("door.dec", 0, 0, 1);
    chk("door.magn_still", magn_on, 1);

    // Stop pauses; start held with stop stays IDLE; releasing stop starts again.
    stopn = 1'b0;
    step();
    chk("stop.magn", magn_on, 0);
    chk_time("stop.frozen", 0, 0, 1);
    startn = 1'b0;
    repeat (3) step();
    chk("stop_start.magn", magn_on, 0);
    stopn = 1'b1;
    step();
    startn = 1'b1;
    chk("stop.resume", magn_on, 1);
    wait_pgt("stop.wait", n);
    step();
    chk_time("stop.end", 0, 0, 0);
    chk("stop.done", timerdone, 1);
    chk("stop.magn_off", magn_on, 0);

    // Enter 1:00 and check the minute borrow.
    switches = key(1); step(); switches = '0; step();
    switches = key(0); step(); switches = '0; step();
    switches = key(0); step(); switches = '0; step();
    chk_time("min.entry", 1, 0, 0);
    chk("min.idle", timerdone, 0);
    startn = 1'b0;
    step();
    startn = 1'b1;
    chk("min.magn", magn_on, 1);
    wait_pgt("min.wait1", n);
    step();
    chk_time("min.borrow", 0, 5, 9);
    wait_pgt("min.wait2", n);
    step();
    chk_time("min.next", 0, 5, 8);

    // Asynchronous clear mid-cook, then the prescaler restarts from zero.
    @(negedge clk);
    #2 clearn = 1'b0;
    #1;
    chk("aclr.magn", magn_on, 0);
    chk("aclr.done", timerdone, 0);
    chk("aclr.pgt", pgt_1Hz, 0);
    chk_time("aclr", 0, 0, 0);
    @(negedge clk);
    clearn = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (pgt_1Hz) begin
        n = i;
        break;
      end
    end
    chk("aclr.first_pgt", n, DIV - 1);
    chk("aclr.idle", magn_on, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
